// File: rtl/glob_acc_strobe_seq_if.sv
// Control/strobe bundle between layer controller, strobe sequencer and global-accumulator pipe.
// Latency: n/a (wiring only).
// Backpressure: n/a; compute_done returns are the only flow control.
interface glob_acc_strobe_seq_if #(
  parameter int THR_W  = 8,
  parameter int BANK_W = 4
);
  // layer controller side
  logic              start;
  logic [5:0]        cfg_rows;
  logic [BANK_W-1:0] cfg_banks;
  logic              cfg_dense;
  logic              cfg_et_en;
  logic [THR_W-1:0]  cfg_et_thr;
  logic              busy;
  logic              job_done;
  logic              err_underflow;
  // global-accumulator pipe side
  logic              compute_done;
  logic [5:0]        ROW_INDEX;
  logic [THR_W-1:0]  ET_THRESHOLD;
  logic              RowIndex_Update;
  logic              BnkCtr_Clr;
  logic              BnkCtr_Latch;
  logic              GlbCtr_Latch;
  logic              MxPl_Sparse_Clr;
  logic              MxPl_Sparse_Latch;
  logic              MxPl_Dense_Clr;
  logic              MxPl_Dense_Latch;
  logic              ET_Thr_Latch;
  logic              ET_L1_Clr;
  logic              ET_L1_En;
  logic              ET_L3_En;

  // sequencer side
  modport slave (
    input  start, cfg_rows, cfg_banks, cfg_dense, cfg_et_en, cfg_et_thr, compute_done,
    output busy, job_done, err_underflow, ROW_INDEX, ET_THRESHOLD, RowIndex_Update,
           BnkCtr_Clr, BnkCtr_Latch, GlbCtr_Latch, MxPl_Sparse_Clr, MxPl_Sparse_Latch,
           MxPl_Dense_Clr, MxPl_Dense_Latch, ET_Thr_Latch, ET_L1_Clr, ET_L1_En, ET_L3_En
  );

  // controller / pipe side
  modport master (
    output start, cfg_rows, cfg_banks, cfg_dense, cfg_et_en, cfg_et_thr, compute_done,
    input  busy, job_done, err_underflow, ROW_INDEX, ET_THRESHOLD, RowIndex_Update,
           BnkCtr_Clr, BnkCtr_Latch, GlbCtr_Latch, MxPl_Sparse_Clr, MxPl_Sparse_Latch,
           MxPl_Dense_Clr, MxPl_Dense_Latch, ET_Thr_Latch, ET_L1_Clr, ET_L1_En, ET_L3_En
  );
endinterface

// File: rtl/glob_acc_strobe_seq.sv
// Per-row strobe sequencer for the global-accumulator pipe, bounding rows in flight via compute_done.
// Latency: first ROW_START one cycle after accept; row period cfg_banks+3 cycles when not stalled.
// Backpressure: parks in WAIT while MAX_OUT rows are outstanding; start ignored while busy.
// Optional: define GACC_SEQ_PERF_EN to add perf_busy_cyc / perf_stall_cyc counters.
module glob_acc_strobe_seq #(
  parameter int THR_W   = 8,
  parameter int BANK_W  = 4,
  parameter int MAX_OUT = 4
) (
  input  logic CLK,
  input  logic RESET_N,
  glob_acc_strobe_seq_if.slave bus
`ifdef GACC_SEQ_PERF_EN
  ,
  output logic [31:0] perf_busy_cyc,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam logic [3:0] MAX_OUT_C = 4'(MAX_OUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_START, S_BANK, S_ROW_END, S_WAIT, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        row_q;
  logic [BANK_W-1:0] bank_q;
  logic [3:0]        out_q, out_d;
  logic [5:0]        cfg_rows_q;
  logic [BANK_W-1:0] cfg_banks_q;
  logic              cfg_dense_q;
  logic              cfg_et_en_q;
  logic [THR_W-1:0]  et_thr_q;
  logic              err_q;
  logic              accept;
  logic              row_end;

  logic job_done_c, riu_c, bclr_c, blat_c, glat_c, sclr_c, slat_c;
  logic dclr_c, dlat_c, ettl_c, l1c_c, l1e_c, l3e_c;

  assign accept  = (state_q == S_IDLE) && bus.start;
  assign row_end = (state_q == S_ROW_END);

  // outstanding-row count after this cycle: increment and return cancel, no decrement below zero
  always_comb begin
    out_d = out_q;
    if (row_end && !bus.compute_done)
      out_d = out_q + 4'd1;
    else if (!row_end && bus.compute_done && (out_q != 4'd0))
      out_d = out_q - 4'd1;
  end

  // state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // next-state and Moore strobe decode (strobes depend on state and registers only)
  always_comb begin
    state_d    = state_q;
    job_done_c = 1'b0;
    riu_c      = 1'b0;
    bclr_c     = 1'b0;
    blat_c     = 1'b0;
    glat_c     = 1'b0;
    sclr_c     = 1'b0;
    slat_c     = 1'b0;
    dclr_c     = 1'b0;
    dlat_c     = 1'b0;
    ettl_c     = 1'b0;
    l1c_c      = 1'b0;
    l1e_c      = 1'b0;
    l3e_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_ROW_START;
      end
      S_ROW_START: begin
        riu_c  = 1'b1;
        bclr_c = !cfg_dense_q;
        sclr_c = !cfg_dense_q;
        dclr_c = cfg_dense_q;
        l1c_c  = cfg_et_en_q;
        ettl_c = cfg_et_en_q && (row_q == 6'd0);
        state_d = S_BANK;
      end
      S_BANK: begin
        blat_c = !cfg_dense_q;
        if (bank_q == cfg_banks_q) state_d = S_ROW_END;
      end
      S_ROW_END: begin
        glat_c = !cfg_dense_q;
        slat_c = !cfg_dense_q;
        dlat_c = cfg_dense_q;
        l1e_c  = cfg_et_en_q;
        l3e_c  = cfg_et_en_q;
        if (row_q == cfg_rows_q)     state_d = S_DRAIN;
        else if (out_d == MAX_OUT_C) state_d = S_WAIT;
        else                         state_d = S_ROW_START;
      end
      S_WAIT: begin
        if (out_q < MAX_OUT_C) state_d = S_ROW_START;
      end
      S_DRAIN: begin
        job_done_c = (out_q == 4'd0);
        if (out_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // job config capture, row/bank counters, outstanding count and sticky underflow
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      row_q       <= '0;
      bank_q      <= '0;
      out_q       <= '0;
      cfg_rows_q  <= '0;
      cfg_banks_q <= '0;
      cfg_dense_q <= 1'b0;
      cfg_et_en_q <= 1'b0;
      et_thr_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        cfg_rows_q  <= bus.cfg_rows;
        cfg_banks_q <= bus.cfg_banks;
        cfg_dense_q <= bus.cfg_dense;
        cfg_et_en_q <= bus.cfg_et_en;
        et_thr_q    <= bus.cfg_et_thr;
        row_q       <= '0;
      end
      if (state_q == S_ROW_START) bank_q <= '0;
      if (state_q == S_BANK)      bank_q <= bank_q + BANK_W'(1);
      if (row_end && (row_q != cfg_rows_q)) row_q <= row_q + 6'd1;
      out_q <= out_d;
      if (bus.compute_done && !row_end && (out_q == 4'd0)) err_q <= 1'b1;
    end
  end

  assign bus.busy              = (state_q != S_IDLE);
  assign bus.job_done          = job_done_c;
  assign bus.err_underflow     = err_q;
  assign bus.ROW_INDEX         = row_q;
  assign bus.ET_THRESHOLD      = et_thr_q;
  assign bus.RowIndex_Update   = riu_c;
  assign bus.BnkCtr_Clr        = bclr_c;
  assign bus.BnkCtr_Latch      = blat_c;
  assign bus.GlbCtr_Latch      = glat_c;
  assign bus.MxPl_Sparse_Clr   = sclr_c;
  assign bus.MxPl_Sparse_Latch = slat_c;
  assign bus.MxPl_Dense_Clr    = dclr_c;
  assign bus.MxPl_Dense_Latch  = dlat_c;
  assign bus.ET_Thr_Latch      = ettl_c;
  assign bus.ET_L1_Clr         = l1c_c;
  assign bus.ET_L1_En          = l1e_c;
  assign bus.ET_L3_En          = l3e_c;

`ifdef GACC_SEQ_PERF_EN
  // saturating busy/stall cycle counters, cleared at accept and frozen once idle
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (accept) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if ((state_q != S_IDLE) && (perf_busy_cyc != 32'hFFFF_FFFF))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if ((state_q == S_WAIT) && (perf_stall_cyc != 32'hFFFF_FFFF))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_glob_acc_strobe_seq.sv
// Directed bench for glob_acc_strobe_seq (MAX_OUT=2) with hand-computed cycle expectations.
// Latency: cycle index c is relative to the cycle start is driven in.
// Backpressure: compute_done is returned on a per-test schedule or withheld.
module tb_glob_acc_strobe_seq;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  glob_acc_strobe_seq_if #(.THR_W(8), .BANK_W(4)) bus ();

`ifdef GACC_SEQ_PERF_EN
  logic [31:0] perf_busy_cyc, perf_stall_cyc;
`endif

  glob_acc_strobe_seq #(.THR_W(8), .BANK_W(4), .MAX_OUT(2)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
`ifdef GACC_SEQ_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;

  localparam int B_JD = 13, B_BUSY = 12, B_RIU = 11, B_BCLR = 10, B_BLAT = 9, B_GLAT = 8;
  localparam int B_SCLR = 7, B_SLAT = 6, B_DCLR = 5, B_DLAT = 4, B_ETTL = 3, B_L1C = 2;
  localparam int B_L1E = 1, B_L3E = 0;
  localparam logic [13:0] M_BUSY = 14'd1 << B_BUSY;
  localparam logic [13:0] M_RIU  = 14'd1 << B_RIU;
  localparam logic [13:0] M_BCLR = 14'd1 << B_BCLR;
  localparam logic [13:0] M_BLAT = 14'd1 << B_BLAT;
  localparam logic [13:0] M_SCLR = 14'd1 << B_SCLR;
  localparam logic [13:0] M_DCLR = 14'd1 << B_DCLR;
  localparam logic [13:0] M_DLAT = 14'd1 << B_DLAT;
  localparam logic [13:0] M_L1C  = 14'd1 << B_L1C;

  logic [13:0] tr     [0:63];
  logic [5:0]  row_tr [0:63];

  function automatic logic [13:0] strobes();
    return {bus.job_done, bus.busy, bus.RowIndex_Update, bus.BnkCtr_Clr, bus.BnkCtr_Latch,
            bus.GlbCtr_Latch, bus.MxPl_Sparse_Clr, bus.MxPl_Sparse_Latch, bus.MxPl_Dense_Clr,
            bus.MxPl_Dense_Latch, bus.ET_Thr_Latch, bus.ET_L1_Clr, bus.ET_L1_En, bus.ET_L3_En};
  endfunction

  function automatic int cnt(input int b, input int n);
    int s = 0;
    for (int c = 0; c < n; c++) s += int'(tr[c][b]);
    return s;
  endfunction

  task automatic set_cfg(input logic [5:0] rows, input logic [3:0] banks, input logic dense,
                         input logic et, input logic [7:0] thr);
    bus.cfg_rows   = rows;
    bus.cfg_banks  = banks;
    bus.cfg_dense  = dense;
    bus.cfg_et_en  = et;
    bus.cfg_et_thr = thr;
  endtask

  // Pulse start in cycle 0, record outputs per cycle, return compute_done cd_delay cycles after
  // each ROW_END (cd_delay<0: withheld) plus one extra pulse in cycle extra_cd.
  task automatic run(input int n, input int cd_delay, input int extra_cd);
    int due[$];
    for (int c = 0; c < n; c++) begin
      @(posedge CLK); #1;
      tr[c]     = strobes();
      row_tr[c] = bus.ROW_INDEX;
      bus.start = (c == 0);
      if (cd_delay >= 0 && (bus.GlbCtr_Latch || bus.MxPl_Dense_Latch)) due.push_back(c + cd_delay);
      bus.compute_done = (c == extra_cd);
      if (due.size() > 0 && due[0] == c) begin
        bus.compute_done = 1'b1;
        void'(due.pop_front());
      end
    end
    bus.start        = 1'b0;
    bus.compute_done = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.compute_done = 1'b0;
    set_cfg(6'd0, 4'd0, 1'b0, 1'b0, 8'h00);
    RESET_N = 1'b1;
    #2 RESET_N = 1'b0;
    @(posedge CLK); #1;
    tests_run++; if (strobes() !== 14'h0) begin tests_failed++;
      $display("FAIL reset_strobes: got %h want %h", strobes(), 14'h0); end
    tests_run++; if (bus.ROW_INDEX !== 6'd0 || bus.ET_THRESHOLD !== 8'h00) begin tests_failed++;
      $display("FAIL reset_regs: got row %h thr %h want 0 0", bus.ROW_INDEX, bus.ET_THRESHOLD); end
    tests_run++; if (bus.err_underflow !== 1'b0) begin tests_failed++;
      $display("FAIL reset_err: got %b want 0", bus.err_underflow); end
    @(negedge CLK) RESET_N = 1'b1;
  endtask

  task automatic test_sparse();
    set_cfg(6'd1, 4'd2, 1'b0, 1'b0, 8'h00);
    run(20, 5, -1);
    tests_run++; if (tr[0][B_BUSY] !== 1'b0 || tr[1][B_BUSY] !== 1'b1) begin tests_failed++;
      $display("FAIL sparse_busy_start: got %b%b want 01", tr[0][B_BUSY], tr[1][B_BUSY]); end
    tests_run++; if (cnt(B_RIU, 20) !== 2 || tr[1][B_RIU] !== 1'b1 || tr[6][B_RIU] !== 1'b1) begin
      tests_failed++; $display("FAIL sparse_riu: got count %0d c1 %b c6 %b want 2 1 1",
                               cnt(B_RIU, 20), tr[1][B_RIU], tr[6][B_RIU]); end
    tests_run++; if (row_tr[1] !== 6'd0 || row_tr[6] !== 6'd1) begin tests_failed++;
      $display("FAIL sparse_row_index: got %0d %0d want 0 1", row_tr[1], row_tr[6]); end
    tests_run++; if (cnt(B_BLAT, 20) !== 6 || cnt(B_GLAT, 20) !== 2) begin tests_failed++;
      $display("FAIL sparse_latches: got blat %0d glat %0d want 6 2", cnt(B_BLAT, 20), cnt(B_GLAT, 20)); end
    tests_run++; if (cnt(B_JD, 20) !== 1 || tr[16][B_JD] !== 1'b1) begin tests_failed++;
      $display("FAIL sparse_job_done: got count %0d c16 %b want 1 1", cnt(B_JD, 20), tr[16][B_JD]); end
    tests_run++; if (cnt(B_DCLR, 20) + cnt(B_DLAT, 20) !== 0 || tr[17][B_BUSY] !== 1'b0) begin
      tests_failed++; $display("FAIL sparse_misc: got dense %0d busy_c17 %b want 0 0",
                               cnt(B_DCLR, 20) + cnt(B_DLAT, 20), tr[17][B_BUSY]); end
  endtask

  task automatic test_dense();
    set_cfg(6'd0, 4'd0, 1'b1, 1'b0, 8'h00);
    run(10, 2, -1);
    tests_run++; if (tr[1] !== (M_BUSY | M_RIU | M_DCLR)) begin tests_failed++;
      $display("FAIL dense_row_start: got %h want %h", tr[1], M_BUSY | M_RIU | M_DCLR); end
    tests_run++; if (tr[2] !== M_BUSY) begin tests_failed++;
      $display("FAIL dense_bank_idle: got %h want %h", tr[2], M_BUSY); end
    tests_run++; if (tr[3] !== (M_BUSY | M_DLAT)) begin tests_failed++;
      $display("FAIL dense_row_end: got %h want %h", tr[3], M_BUSY | M_DLAT); end
    tests_run++; if (cnt(B_BCLR, 10) + cnt(B_BLAT, 10) + cnt(B_GLAT, 10) + cnt(B_SCLR, 10)
                     + cnt(B_SLAT, 10) !== 0) begin tests_failed++;
      $display("FAIL dense_no_sparse: got %0d want 0", cnt(B_BCLR, 10) + cnt(B_BLAT, 10)
               + cnt(B_GLAT, 10) + cnt(B_SCLR, 10) + cnt(B_SLAT, 10)); end
    tests_run++; if (tr[6][B_JD] !== 1'b1 || cnt(B_JD, 10) !== 1) begin tests_failed++;
      $display("FAIL dense_job_done: got c6 %b count %0d want 1 1", tr[6][B_JD], cnt(B_JD, 10)); end
  endtask

  // compute_done returned in the same cycle as every ROW_END: count never moves, no underflow
  task automatic test_et();
    set_cfg(6'd2, 4'd1, 1'b0, 1'b1, 8'h5A);
    run(16, 0, -1);
    tests_run++; if (cnt(B_ETTL, 16) !== 1 || tr[1][B_ETTL] !== 1'b1) begin tests_failed++;
      $display("FAIL et_thr_latch: got count %0d c1 %b want 1 1", cnt(B_ETTL, 16), tr[1][B_ETTL]); end
    tests_run++; if (bus.ET_THRESHOLD !== 8'h5A) begin tests_failed++;
      $display("FAIL et_threshold: got %h want 5a", bus.ET_THRESHOLD); end
    tests_run++; if (cnt(B_L1C, 16) !== 3 || cnt(B_L1E, 16) !== 3 || cnt(B_L3E, 16) !== 3) begin
      tests_failed++; $display("FAIL et_counts: got l1c %0d l1e %0d l3e %0d want 3 3 3",
                               cnt(B_L1C, 16), cnt(B_L1E, 16), cnt(B_L3E, 16)); end
    tests_run++; if (tr[5] !== (M_BUSY | M_RIU | M_BCLR | M_SCLR | M_L1C)) begin tests_failed++;
      $display("FAIL et_row1_start: got %h want %h", tr[5], M_BUSY | M_RIU | M_BCLR | M_SCLR | M_L1C); end
    tests_run++; if (tr[13][B_JD] !== 1'b1 || bus.err_underflow !== 1'b0) begin tests_failed++;
      $display("FAIL et_coincident_done: got jd_c13 %b err %b want 1 0", tr[13][B_JD], bus.err_underflow); end
  endtask

  task automatic test_max_out();
    set_cfg(6'd4, 4'd0, 1'b0, 1'b0, 8'h00);
    run(12, -1, -1);
    tests_run++; if (cnt(B_GLAT, 12) !== 2 || tr[7] !== M_BUSY || tr[11] !== M_BUSY) begin
      tests_failed++; $display("FAIL maxout_stall: got glat %0d c7 %h c11 %h want 2 %h %h",
                               cnt(B_GLAT, 12), tr[7], tr[11], M_BUSY, M_BUSY); end
    @(posedge CLK); #1;
    bus.compute_done = 1'b1;
    @(posedge CLK); #1;
    bus.compute_done = 1'b0;
    tests_run++; if (strobes() !== M_BUSY) begin tests_failed++;
      $display("FAIL maxout_wait_hold: got %h want %h", strobes(), M_BUSY); end
    // start in cycle 0 lands on a busy sequencer and must be ignored
    run(13, 0, 9);
    tests_run++; if (tr[0][B_RIU] !== 1'b1 || row_tr[0] !== 6'd2) begin tests_failed++;
      $display("FAIL maxout_resume: got riu %b row %0d want 1 2", tr[0][B_RIU], row_tr[0]); end
    tests_run++; if (cnt(B_GLAT, 13) !== 3 || cnt(B_JD, 13) !== 1 || tr[10][B_JD] !== 1'b1) begin
      tests_failed++; $display("FAIL maxout_finish: got glat %0d jd %0d jd_c10 %b want 3 1 1",
                               cnt(B_GLAT, 13), cnt(B_JD, 13), tr[10][B_JD]); end
    tests_run++; if (tr[12][B_BUSY] !== 1'b0) begin tests_failed++;
      $display("FAIL maxout_idle: got busy %b want 0", tr[12][B_BUSY]); end
  endtask

  task automatic test_underflow();
    @(posedge CLK); #1;
    bus.compute_done = 1'b1;
    @(posedge CLK); #1;
    bus.compute_done = 1'b0;
    tests_run++; if (bus.err_underflow !== 1'b1 || bus.busy !== 1'b0) begin tests_failed++;
      $display("FAIL underflow_set: got err %b busy %b want 1 0", bus.err_underflow, bus.busy); end
    repeat (3) @(posedge CLK);
    #1;
    tests_run++; if (bus.err_underflow !== 1'b1 || bus.job_done !== 1'b0) begin tests_failed++;
      $display("FAIL underflow_sticky: got err %b jd %b want 1 0", bus.err_underflow, bus.job_done); end
  endtask

  task automatic test_reset_mid();
    set_cfg(6'd3, 4'd3, 1'b0, 1'b0, 8'h33);
    run(9, 2, -1);
    tests_run++; if (tr[8] !== (M_BUSY | M_BLAT) || row_tr[8] !== 6'd1) begin tests_failed++;
      $display("FAIL midrst_in_bank1: got %h row %0d want %h 1", tr[8], row_tr[8], M_BUSY | M_BLAT); end
    #2 RESET_N = 1'b0;
    #1;
    tests_run++; if (strobes() !== 14'h0 || bus.ROW_INDEX !== 6'd0) begin tests_failed++;
      $display("FAIL midrst_outputs: got %h row %0d want 0 0", strobes(), bus.ROW_INDEX); end
    tests_run++; if (bus.ET_THRESHOLD !== 8'h00 || bus.err_underflow !== 1'b0) begin tests_failed++;
      $display("FAIL midrst_regs: got thr %h err %b want 00 0", bus.ET_THRESHOLD, bus.err_underflow); end
    @(negedge CLK) RESET_N = 1'b1;
    set_cfg(6'd0, 4'd0, 1'b0, 1'b0, 8'h00);
    run(8, 1, -1);
    tests_run++; if (tr[1] !== (M_BUSY | M_RIU | M_BCLR | M_SCLR) || row_tr[1] !== 6'd0) begin
      tests_failed++; $display("FAIL midrst_restart: got %h row %0d want %h 0",
                               tr[1], row_tr[1], M_BUSY | M_RIU | M_BCLR | M_SCLR); end
    tests_run++; if (cnt(B_JD, 8) !== 1 || tr[5][B_JD] !== 1'b1) begin tests_failed++;
      $display("FAIL midrst_job_done: got count %0d c5 %b want 1 1", cnt(B_JD, 8), tr[5][B_JD]); end
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_dense();
    test_et();
    test_max_out();
    test_underflow();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
